simd_adder_arbiter: RTL

Shares one packed-SIMD `full_adder` (32-bit, 1×32/2×16/4×8 lanes, add/sub) between NUM_REQ requesters. Each requester presents operands, lane size and op over a valid/ready handshake. The block grants one request per cycle round-robin, latches its operands, drives the shared adder from those latched operands, and returns the result on a single response channel tagged with the requester ID. It sits between the core's execute-stage clients (e.g. the scalar ALU path and the packed-SIMD unit) and the adder datapath.

---
 rtl/simd_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/simd_adder_arbiter.sv | 62 ++++++
 4 files changed

// File: rtl/simd_adder_pkg.sv
// simd_adder_pkg: shared types for the arbitrated packed-SIMD adder
package simd_adder_pkg;
   typedef enum logic [1:0] {SZ32 = 2'b00, SZ16 = 2'b01, SZ8 = 2'b10, SZ_RSVD = 2'b11} lane_size_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      lane_size_t  size;
      logic        op;
   } simd_req_t;
   typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: 32-bit packed-SIMD add/sub with 1x32, 2x16 or 4x8 lanes
module full_adder
   import simd_adder_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  lane_size_t  size,
   input  logic        op,
   output logic [31:0] r
);
   logic [31:0] bx;
   logic        c;
   logic [8:0]  s;
   always_comb begin
      bx = (op == OP_SUB) ? ~b : b;
      c = (op == OP_SUB);
      s = '0;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         // each lane restarts with the op's carry-in, so nothing crosses a lane boundary
         if ((i == 2 && (size == SZ16 || size == SZ8)) || (i % 2 == 1 && size == SZ8)) c = (op == OP_SUB);
         s = {1'b0, a[8*i +: 8]} + {1'b0, bx[8*i +: 8]} + {8'd0, c};
         r[8*i +: 8] = s[7:0];
         c = s[8];
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting the search after the last winner
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    gid
);
   logic [ID_W-1:0] last;
   logic            found;
   int              idx;
   always_comb begin
      grant = '0;
      gid = last;
      found = 1'b0;
      idx = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (en && !found && req[idx[ID_W-1:0]]) begin
            grant[idx[ID_W-1:0]] = 1'b1;
            gid = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      if (!rst_n) last <= ID_W'(NUM_REQ - 1);
      else if (found) last <= gid;
endmodule

// File: rtl/simd_adder_arbiter.sv
// simd_adder_arbiter: round-robin sharing of one packed-SIMD adder among NUM_REQ requesters
module simd_adder_arbiter
   import simd_adder_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    REQ_VALID_i,
   output logic [NUM_REQ-1:0]    REQ_READY_o,
   input  logic [NUM_REQ*32-1:0] REQ_A_i,
   input  logic [NUM_REQ*32-1:0] REQ_B_i,
   input  logic [NUM_REQ*2-1:0]  REQ_SIZE_i,
   input  logic [NUM_REQ-1:0]    REQ_OP_i,
   output logic                  RSP_VALID_o,
   input  logic                  RSP_READY_i,
   output logic [ID_W-1:0]       RSP_ID_o,
   output logic [31:0]           RSP_R_o,
   output logic                  RSP_ERR_o
);
   state_t          state, state_n;
   simd_req_t       req_q, req_d;
   logic [ID_W-1:0] id_q, gid;
   logic            can_accept, fire, rsp_fire;
   assign RSP_VALID_o = (state == RESP);
   assign rsp_fire    = RSP_VALID_o && RSP_READY_i;
   assign can_accept  = (state == IDLE) || rsp_fire;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (REQ_VALID_i),
      .en    (can_accept && rst_n),
      .grant (REQ_READY_o),
      .gid   (gid)
   );
   assign fire  = |REQ_READY_o;
   assign req_d = '{a: REQ_A_i[32*gid +: 32], b: REQ_B_i[32*gid +: 32],
                    size: lane_size_t'(REQ_SIZE_i[2*gid +: 2]), op: REQ_OP_i[gid]};
   always_comb state_n = fire ? RESP : rsp_fire ? IDLE : state;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk)
      if (!rst_n) begin
         req_q <= '0;
         id_q <= '0;
      end else if (fire) begin
         req_q <= req_d;
         id_q <= gid;
      end
   // reserved size still computes as one 32-bit lane, flagged through RSP_ERR_o
   full_adder u_add (
      .a    (req_q.a),
      .b    (req_q.b),
      .size (req_q.size == SZ_RSVD ? SZ32 : req_q.size),
      .op   (req_q.op),
      .r    (RSP_R_o)
   );
   assign RSP_ID_o  = id_q;
   assign RSP_ERR_o = (req_q.size == SZ_RSVD);
endmodule
